// File: rtl/eco32f_prefetch.sv
// rtl/eco32f_prefetch.sv - ECO32F instruction prefetch unit with Wishbone burst fetch
//
// Fetches aligned instruction blocks over a Wishbone B4 incrementing burst and
// feeds them through an instruction queue to the decode stage.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   redirect/redirect_pc flush the queue and restart fetching at redirect_pc
//   id_*                 queue head towards decode (valid/ready handshake)
//   iwbm_*               Wishbone instruction-bus master
//
// Build option: ECO32F_PREFETCH_RTY_EN - a retry response ends the bus cycle and
// the remainder of the block is re-requested; without it a retry is a bus fault.

module eco32f_prefetch #(
  parameter logic [31:0] RESET_PC  = 32'he0000000,
  parameter int          BURST_LEN = 8,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_insn,
  output logic        id_exc_ibus_fault,
  output logic [31:0] iwbm_adr_o,
  output logic        iwbm_stb_o,
  output logic        iwbm_cyc_o,
  output logic [3:0]  iwbm_sel_o,
  output logic        iwbm_we_o,
  output logic [2:0]  iwbm_cti_o,
  output logic [1:0]  iwbm_bte_o,
  output logic [31:0] iwbm_dat_o,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  input  logic        iwbm_rty_i,
  input  logic [31:0] iwbm_dat_i
);

  localparam logic [31:0] ECO32F_INSN_NOP = 32'h1500_0000;
  localparam int OFS_W = $clog2(BURST_LEN);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, BURST, HALT} state_t;

  state_t        state, state_nxt;
  // Holds the next fetch address while idle and the current beat address in a burst.
  logic [31:0]   adr, adr_nxt;
  // Keeps the first edge after reset free of start decisions.
  logic          armed;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_insn [DEPTH];
  logic          q_fault[DEPTH];

  logic          enq, enq_fault, deq, last_beat, bus_fault, bus_retry;
  logic [31:0]   enq_insn;
  logic [CW-1:0] burst_n, free_slots;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

`ifdef ECO32F_PREFETCH_RTY_EN
  assign bus_fault = iwbm_err_i;
  assign bus_retry = iwbm_rty_i;
`else
  assign bus_fault = iwbm_err_i | iwbm_rty_i;
  assign bus_retry = 1'b0;
`endif

  // Beats left to the end of the aligned block; the burst always stops there,
  // so it can never cross a block boundary.
  assign last_beat  = &adr[OFS_W+1:2];
  assign burst_n    = CW'(BURST_LEN) - CW'(adr[OFS_W+1:2]);
  assign free_slots = CW'(DEPTH) - count;

  assign id_valid          = (count != '0);
  assign id_pc             = id_valid ? q_pc[rd_ptr] : 32'h0;
  assign id_insn           = id_valid ? q_insn[rd_ptr] : ECO32F_INSN_NOP;
  assign id_exc_ibus_fault = id_valid & q_fault[rd_ptr];
  assign deq               = id_valid & id_ready & ~redirect;

  assign iwbm_adr_o = adr;
  assign iwbm_cyc_o = (state == BURST);
  assign iwbm_stb_o = (state == BURST);
  assign iwbm_cti_o = (state == BURST && !last_beat) ? 3'b010 : 3'b111;
  assign iwbm_sel_o = 4'b1111;
  assign iwbm_we_o  = 1'b0;
  assign iwbm_dat_o = 32'h0;
  assign iwbm_bte_o = 2'b00;

  // A burst only starts when every beat it can return already has a free
  // slot, so count plus outstanding beats never exceeds DEPTH. A retried
  // remainder needs no more slots than were set aside for it originally.
  always_comb begin
    state_nxt = state;
    adr_nxt   = adr;
    enq       = 1'b0;
    enq_insn  = iwbm_dat_i;
    enq_fault = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && free_slots >= burst_n) state_nxt = BURST;
      end
      BURST: begin
        if (bus_fault) begin
          enq       = 1'b1;
          enq_insn  = ECO32F_INSN_NOP;
          enq_fault = 1'b1;
          state_nxt = HALT;
        end else if (bus_retry) begin
          state_nxt = IDLE;
        end else if (iwbm_ack_i) begin
          enq     = 1'b1;
          adr_nxt = adr + 32'd4;
          if (last_beat) state_nxt = IDLE;
        end
      end
      HALT: begin
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      state_nxt = IDLE;
      adr_nxt   = {redirect_pc[31:2], 2'b00};
      enq       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      adr    <= RESET_PC;
      armed  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      adr   <= adr_nxt;
      armed <= 1'b1;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= adr;
      q_insn[wr_ptr]  <= enq_insn;
      q_fault[wr_ptr] <= enq_fault;
    end
  end

endmodule
